spi_word_rx: RTL

//   Parametrised SPI receive deserializer. Shifts serial din into WIDTH-bit words
//   on each en strobe (en = one-cycle pulse from the synchronized SCLK sample edge).

---
 rtl/spi_word_rx.sv | 121 ++++++++++++
 1 files changed

// File: rtl/spi_word_rx.sv
// SPI receive deserializer: shifts din into WIDTH-bit words on each en strobe.
// Frames on cs_n and hands words out over a single-slot valid/ready port.
module spi_word_rx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             cs_n,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [CNT_W-1:0] word_cnt,
    output logic             frame_done,
    output logic             frame_err,
    output logic             overrun,
    input  logic             ovr_clr
);

    localparam int BCW = $clog2(WIDTH);
    localparam logic [BCW-1:0]   LAST_BIT = BCW'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [BCW-1:0]   bit_cnt_q;
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;
    logic [CNT_W-1:0] word_cnt_q;
    logic             frame_done_q;
    logic             frame_err_q;
    logic             overrun_q;
    logic             slot_free;

    // sr_d is the shift register with the current din already included,
    // so on the last bit of a word it is the completed word itself.
    always_comb begin
        sr_d = sr_q;
        if (MSB_FIRST) begin
            sr_d = {sr_q[WIDTH-2:0], din};
        end else begin
            sr_d = {din, sr_q[WIDTH-1:1]};
        end
    end

    assign slot_free = !dout_valid_q || dout_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            word_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (dout_valid_q && dout_ready) begin
                dout_valid_q <= 1'b0;
            end
            // Clear first so a same-cycle overrun set below takes priority.
            if (ovr_clr) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (!cs_n) begin
                        state_q    <= SHIFT;
                        bit_cnt_q  <= '0;
                        sr_q       <= '0;
                        word_cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    if (cs_n) begin
                        state_q      <= IDLE;
                        frame_done_q <= 1'b1;
                        frame_err_q  <= (bit_cnt_q != '0);
                        bit_cnt_q    <= '0;
                    end else if (en) begin
                        sr_q <= sr_d;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            if (slot_free) begin
                                dout_q       <= sr_d;
                                dout_valid_q <= 1'b1;
                                if (word_cnt_q != CNT_MAX) begin
                                    word_cnt_q <= word_cnt_q + CNT_W'(1);
                                end
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign word_cnt   = word_cnt_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule
